// File: rtl/detection_decision.sv
// detection_decision: EMA smoothing of a u1c15f probability stream followed by a
// hysteresis FSM with N-sample confirmation. Optional idle timeout: DECISION_TIMEOUT_EN.
module detection_decision #(
    parameter int          ALPHA_SHIFT = 3,
    parameter logic [15:0] TH_ON       = 16'h6000,
    parameter logic [15:0] TH_OFF      = 16'h4000,
    parameter int          CONFIRM_CNT = 3
`ifdef DECISION_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] probability_in,
    output logic        valid_out,
    output logic [15:0] probability_filtered,
    output logic        detected,
    output logic        detect_rise,
    output logic        detect_fall
);

    localparam int          CW  = $clog2(CONFIRM_CNT + 1);
    localparam logic [15:0] ONE = 16'h8000;

    typedef enum logic [1:0] {IDLE, PEND_ON, ACTIVE, PEND_OFF} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cntInc;
    logic [15:0]        acc_q, acc_d, accStep, pClamp;
    logic               primed_q, primed_d;
    logic               s1Valid_q;
    logic               vOut_q, vOut_d;
    logic [15:0]        filt_q, filt_d;
    logic               det_q, det_d, rise_q, rise_d, fall_q, fall_d;
    logic               newDet, qualOn, qualOff, timeout;
    logic signed [16:0] diff, step;
    logic signed [17:0] sum;

    assign pClamp = (probability_in > ONE) ? ONE : probability_in;
    assign diff   = $signed({1'b0, pClamp}) - $signed({1'b0, acc_q});
    assign step   = diff >>> ALPHA_SHIFT;
    assign sum    = $signed({2'b00, acc_q}) + $signed({step[16], step});

    always_comb begin
        if (sum[17])
            accStep = '0;
        else if (sum > 18'sh08000)
            accStep = ONE;
        else
            accStep = sum[15:0];
    end

`ifdef DECISION_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;

    // Counter saturates at the limit so a single idle stretch clears only once.
    always_comb begin
        idle_d = idle_q;
        if (valid_in)
            idle_d = '0;
        else if (idle_q != 32'(TIMEOUT_CYCLES))
            idle_d = idle_q + 32'd1;
    end

    assign timeout = !valid_in && (idle_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        acc_d    = acc_q;
        primed_d = primed_q;
        if (valid_in) begin
            if (!primed_q) begin
                acc_d    = pClamp;
                primed_d = 1'b1;
            end else begin
                acc_d = accStep;
            end
        end else if (timeout) begin
            primed_d = 1'b0;
        end
    end

    assign qualOn  = (acc_q >= TH_ON);
    assign qualOff = (acc_q < TH_OFF);
    assign cntInc  = (cnt_q == CW'(CONFIRM_CNT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (timeout) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (s1Valid_q) begin
            case (state_q)
                IDLE: if (qualOn) begin
                    cnt_d   = CW'(1);
                    state_d = (CONFIRM_CNT == 1) ? ACTIVE : PEND_ON;
                end
                PEND_ON: if (qualOn) begin
                    cnt_d = cntInc;
                    if (cntInc == CW'(CONFIRM_CNT))
                        state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                ACTIVE: if (qualOff) begin
                    cnt_d   = CW'(1);
                    state_d = (CONFIRM_CNT == 1) ? IDLE : PEND_OFF;
                end
                PEND_OFF: if (qualOff) begin
                    cnt_d = cntInc;
                    if (cntInc == CW'(CONFIRM_CNT))
                        state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign newDet = (state_d == ACTIVE) || (state_d == PEND_OFF);

    // A timeout fall pulse is the only output event not qualified by valid_out.
    always_comb begin
        vOut_d = s1Valid_q;
        filt_d = filt_q;
        det_d  = det_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (timeout) begin
            vOut_d = 1'b0;
            filt_d = '0;
            det_d  = 1'b0;
            fall_d = det_q;
        end else if (s1Valid_q) begin
            filt_d = acc_q;
            det_d  = newDet;
            rise_d = newDet & ~det_q;
            fall_d = ~newDet & det_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            primed_q  <= 1'b0;
            s1Valid_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            vOut_q    <= 1'b0;
            filt_q    <= '0;
            det_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            primed_q  <= primed_d;
            s1Valid_q <= valid_in;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vOut_q    <= vOut_d;
            filt_q    <= filt_d;
            det_q     <= det_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign valid_out            = vOut_q;
    assign probability_filtered = filt_q;
    assign detected             = det_q;
    assign detect_rise          = rise_q;
    assign detect_fall          = fall_q;

endmodule
